// File: rtl/quat_tx_scheduler.sv
// Buffers quaternion result frames and presents them one at a time to an SPI transmitter.
// Optional feature macro: QSCHED_SEQNUM_EN (8-bit sequence tag on presented frames).
module quat_tx_scheduler #(
  parameter int unsigned DEPTH = 4
) (
  input  logic                      sclk,
  input  logic                      rst,
  input  logic                      in_valid,
  input  logic [31:0]               in_q0,
  input  logic [31:0]               in_q1,
  input  logic [31:0]               in_q2,
  input  logic [31:0]               in_q3,
  output logic                      in_ready,
  input  logic                      cs,
  input  logic                      data_ready,
  output logic [31:0]               q0,
  output logic [31:0]               q1,
  output logic [31:0]               q2,
  output logic [31:0]               q3,
  output logic                      frame_valid,
  output logic                      aborted,
  output logic                      overflow,
  output logic [7:0]                seq_num,
  output logic [$clog2(DEPTH):0]    level
);

  localparam int unsigned PW = $clog2(DEPTH);
  localparam int unsigned LW = PW + 1;

  typedef enum logic [1:0] {
    IDLE,
    ARMED,
    SEND,
    RELEASE
  } state_e;

  state_e          state_q, state_d;
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [LW-1:0]   level_q, level_d;
  logic [127:0]    mem_q [DEPTH];
  logic [127:0]    mem_d [DEPTH];
  logic [127:0]    frame_q, frame_d;
  logic            aborted_q, aborted_d;
  logic            overflow_q, overflow_d;
  logic            push, pop, load;

  always_comb begin
    push      = in_valid && (level_q != LW'(DEPTH));
    pop       = 1'b0;
    load      = 1'b0;
    aborted_d = 1'b0;
    state_d   = state_q;
    unique case (state_q)
      IDLE: begin
        if (level_q != '0) begin
          load    = 1'b1;
          state_d = ARMED;
        end
      end
      ARMED: begin
        if (!cs) state_d = SEND;
      end
      SEND: begin
        // Completion wins over a coincident cs rise.
        if (data_ready) begin
          pop     = 1'b1;
          state_d = RELEASE;
        end else if (cs) begin
          aborted_d = 1'b1;
          state_d   = ARMED;
        end
      end
      RELEASE: begin
        if (cs) begin
          if (level_q != '0) begin
            load    = 1'b1;
            state_d = ARMED;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    mem_d = mem_q;
    if (push) mem_d[wr_ptr_q] = {in_q0, in_q1, in_q2, in_q3};
    wr_ptr_d   = push ? wr_ptr_q + PW'(1) : wr_ptr_q;
    rd_ptr_d   = pop  ? rd_ptr_q + PW'(1) : rd_ptr_q;
    level_d    = level_q;
    if (push && !pop) level_d = level_q + LW'(1);
    if (!push && pop) level_d = level_q - LW'(1);
    frame_d    = load ? mem_q[rd_ptr_q] : frame_q;
    overflow_d = overflow_q || (in_valid && !push);
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      level_q    <= '0;
      frame_q    <= '0;
      aborted_q  <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      level_q    <= level_d;
      frame_q    <= frame_d;
      aborted_q  <= aborted_d;
      overflow_q <= overflow_d;
    end
  end

  // Frame storage carries no reset; pointers and level define validity.
  always_ff @(posedge sclk) begin
    mem_q <= mem_d;
  end

`ifdef QSCHED_SEQNUM_EN
  logic [7:0] pop_cnt_q, pop_cnt_d;
  logic [7:0] seq_q, seq_d;

  always_comb begin
    pop_cnt_d = pop ? pop_cnt_q + 8'd1 : pop_cnt_q;
    seq_d     = load ? pop_cnt_q : seq_q;
  end

  always_ff @(posedge sclk) begin
    if (rst) begin
      pop_cnt_q <= '0;
      seq_q     <= '0;
    end else begin
      pop_cnt_q <= pop_cnt_d;
      seq_q     <= seq_d;
    end
  end

  assign seq_num = seq_q;
`else
  assign seq_num = '0;
`endif

  assign in_ready    = (level_q != LW'(DEPTH));
  assign level       = level_q;
  assign frame_valid = (state_q == ARMED) || (state_q == SEND);
  assign aborted     = aborted_q;
  assign overflow    = overflow_q;
  assign {q0, q1, q2, q3} = frame_q;

endmodule

// File: tb/tb_quat_tx_scheduler.sv
// Randomized and directed bench for quat_tx_scheduler against a queue-based transaction model.
module tb_quat_tx_scheduler;
  localparam int unsigned DEPTH = 4;

  logic        sclk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in_q0 = '0, in_q1 = '0, in_q2 = '0, in_q3 = '0;
  logic        in_ready;
  logic        cs = 1'b1;
  logic        data_ready = 1'b0;
  logic [31:0] q0, q1, q2, q3;
  logic        frame_valid, aborted, overflow;
  logic [7:0]  seq_num;
  logic [$clog2(DEPTH):0] level;

  always #5 sclk = ~sclk;

  quat_tx_scheduler #(.DEPTH(DEPTH)) dut (
    .sclk(sclk), .rst(rst), .in_valid(in_valid),
    .in_q0(in_q0), .in_q1(in_q1), .in_q2(in_q2), .in_q3(in_q3),
    .in_ready(in_ready), .cs(cs), .data_ready(data_ready),
    .q0(q0), .q1(q1), .q2(q2), .q3(q3),
    .frame_valid(frame_valid), .aborted(aborted), .overflow(overflow),
    .seq_num(seq_num), .level(level)
  );

  int unsigned n_vec = 0;
  int unsigned n_bad = 0;

  task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Transaction model: queue of buffered frames, the frame on offer, and where the
  // host is in its handshake (nothing offered / offered / being read / awaiting cs rise).
  logic [127:0] m_fifo[$];
  logic [127:0] m_pres = '0;
  bit           m_offered = 0, m_reading = 0, m_draining = 0;
  bit           m_abort = 0, m_ovf = 0;
  logic [7:0]   m_pops = '0, m_seq = '0;

  task automatic model_edge(input bit v, input logic [127:0] d, input bit c, input bit dr, input bit r);
    int  sz;
    bit  full;
    bit  took;
    if (r) begin
      m_fifo.delete();
      m_pres = '0; m_offered = 0; m_reading = 0; m_draining = 0;
      m_abort = 0; m_ovf = 0; m_pops = '0; m_seq = '0;
      return;
    end
    sz   = m_fifo.size();
    full = (sz == DEPTH);
    took = 0;
    m_abort = 0;
    if (v && full) m_ovf = 1;
    if (m_reading) begin
      if (dr) begin
        took = 1; m_reading = 0; m_draining = 1;
      end else if (c) begin
        m_abort = 1; m_reading = 0; m_offered = 1;
      end
    end else if (m_offered) begin
      if (!c) begin m_offered = 0; m_reading = 1; end
    end else if (!m_draining || c) begin
      m_draining = 0;
      if (sz > 0) begin
        m_pres = m_fifo[0]; m_seq = m_pops; m_offered = 1;
      end
    end
    if (took) begin
      void'(m_fifo.pop_front());
      m_pops = m_pops + 8'd1;
    end
    if (v && !full) m_fifo.push_back(d);
  endtask

  task automatic check_all();
    logic [7:0] exp_seq;
`ifdef QSCHED_SEQNUM_EN
    exp_seq = m_seq;
`else
    exp_seq = 8'd0;
`endif
    check_eq("frame_valid", 128'(frame_valid), 128'(m_offered || m_reading));
    check_eq("q", {q0, q1, q2, q3}, m_pres);
    check_eq("level", 128'(level), 128'(m_fifo.size()));
    check_eq("in_ready", 128'(in_ready), 128'(m_fifo.size() != DEPTH));
    check_eq("aborted", 128'(aborted), 128'(m_abort));
    check_eq("overflow", 128'(overflow), 128'(m_ovf));
    check_eq("seq_num", 128'(seq_num), 128'(exp_seq));
  endtask

  task automatic step(input bit v, input logic [127:0] d, input bit c, input bit dr, input bit r);
    in_valid = v;
    {in_q0, in_q1, in_q2, in_q3} = d;
    cs = c; data_ready = dr; rst = r;
    @(posedge sclk);
    model_edge(v, d, c, dr, r);
    @(negedge sclk);
    check_all();
  endtask

  function automatic logic [127:0] rnd_frame();
    return {$urandom(), $urandom(), $urandom(), $urandom()};
  endfunction

  logic [127:0] fa, fb, fc;
  bit           rc;

  initial begin
    fa = {32'h11111111, 32'h22222222, 32'h33333333, 32'h44444444};
    fb = rnd_frame();
    fc = rnd_frame();
    @(negedge sclk);

    // Reset state
    step(0, '0, 1, 0, 1);
    check_eq("rst_level", 128'(level), 128'd0);
    check_eq("rst_fv", 128'(frame_valid), 128'd0);

    // Single push presented one edge later
    step(1, fa, 1, 0, 0);
    check_eq("a_fv_early", 128'(frame_valid), 128'd0);
    step(0, '0, 1, 0, 0);
    check_eq("a_q0", 128'(q0), 128'h11111111);
    check_eq("a_fv", 128'(frame_valid), 128'd1);
    check_eq("a_level", 128'(level), 128'd1);

    // Fill past capacity with no transfers
    step(0, '0, 1, 0, 1);
    for (int i = 0; i < 5; i++) step(1, rnd_frame(), 1, 0, 0);
    check_eq("full_ready", 128'(in_ready), 128'd0);
    check_eq("full_ovf", 128'(overflow), 128'd1);
    check_eq("full_level", 128'(level), 128'd4);

    // Completed transfer; next frame shown only after cs rises
    step(0, '0, 1, 0, 1);
    step(1, fa, 1, 0, 0);
    step(1, fb, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 1, 0);
    check_eq("xfer_level", 128'(level), 128'd1);
    step(0, '0, 0, 0, 0);
    check_eq("xfer_hold_q", {q0, q1, q2, q3}, fa);
    step(0, '0, 1, 0, 0);
    check_eq("xfer_new_q", {q0, q1, q2, q3}, fb);

    // Aborted read
    step(0, '0, 1, 0, 1);
    step(1, fa, 1, 0, 0);
    step(1, fb, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    for (int i = 0; i < 10; i++) step(0, '0, 0, 0, 0);
    step(0, '0, 1, 0, 0);
    check_eq("abort_pulse", 128'(aborted), 128'd1);
    check_eq("abort_q", {q0, q1, q2, q3}, fa);
    step(0, '0, 1, 0, 0);
    check_eq("abort_once", 128'(aborted), 128'd0);
    check_eq("abort_level", 128'(level), 128'd2);

    // Reset mid-read discards everything
    step(0, '0, 1, 0, 1);
    for (int i = 0; i < 3; i++) step(1, rnd_frame(), 1, 0, 0);
    step(0, '0, 0, 0, 0);
    step(0, '0, 0, 0, 1);
    check_eq("midrst_level", 128'(level), 128'd0);
    check_eq("midrst_q", {q0, q1, q2, q3}, 128'd0);
    step(1, fc, 1, 0, 0);
    step(0, '0, 1, 0, 0);
    check_eq("midrst_next_q", {q0, q1, q2, q3}, fc);

    // 257 complete transfers (sequence tag wrap)
    step(0, '0, 1, 0, 1);
    for (int i = 0; i < 257; i++) begin
      step(1, rnd_frame(), 1, 0, 0);
      step(0, '0, 1, 0, 0);
      step(0, '0, 0, 0, 0);
      step(0, '0, 0, 1, 0);
      step(0, '0, 1, 0, 0);
    end

    // Random traffic
    step(0, '0, 1, 0, 1);
    rc = 1;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(3) == 0) rc = ~rc;
      step(($urandom_range(2) != 0), rnd_frame(), rc,
           ($urandom_range(3) == 0), ($urandom_range(499) == 0));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end
endmodule
